// File: rtl/arb4_1_if.sv
// arb4_1_if: request/grant bundle between requesters and the 4:1 mux arbiter
interface arb4_1_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] s;
   logic       busy;
   modport master (output req, input gnt, s, busy);
   modport slave  (input req, output gnt, s, busy);
endinterface

// File: rtl/arb4_1.sv
// arb4_1: round-robin owner arbiter for a shared 4:1 mux with bounded hold time
module arb4_1 #(
   parameter int MAXHOLD = 8
) (
   input logic      clk,
   input logic      reset_n,
   arb4_1_if.slave  bus
);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d, owner_q, owner_d, s_q, s_d;
   logic [4:0] hcnt_q, hcnt_d;
   logic [3:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;
   logic [1:0] base, win, idx;
   logic       found, hold;
   // search starts just past the owner on release, else at the idle pointer; lowest offset wins
   always_comb begin
      base  = (state_q == GRANT) ? owner_q + 2'd1 : ptr_q;
      win   = base;
      idx   = base;
      found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         idx = base + 2'(i);
         if (bus.req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end
   // owner keeps the grant while requesting and under the hold limit; otherwise re-arbitrate with no bubble
   always_comb begin
      hold    = (state_q == GRANT) && bus.req[owner_q] && (hcnt_q < 5'(MAXHOLD));
      state_d = state_q;
      owner_d = owner_q;
      s_d     = s_q;
      gnt_d   = gnt_q;
      busy_d  = busy_q;
      hcnt_d  = hcnt_q;
      ptr_d   = (state_q == GRANT && !hold) ? owner_q + 2'd1 : ptr_q;
      if (hold) begin
         hcnt_d = hcnt_q + 5'd1;
      end else if (found) begin
         state_d = GRANT;
         owner_d = win;
         s_d     = win;
         gnt_d   = 4'b0001 << win;
         busy_d  = 1'b1;
         hcnt_d  = 5'd1;
      end else begin
         state_d = IDLE;
         gnt_d   = 4'b0000;
         busy_d  = 1'b0;
      end
   end
   // state and registered outputs, cleared asynchronously
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         owner_q <= 2'd0;
         s_q     <= 2'd0;
         gnt_q   <= 4'd0;
         busy_q  <= 1'b0;
         hcnt_q  <= 5'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         s_q     <= s_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
         hcnt_q  <= hcnt_d;
      end
   end
   assign bus.gnt  = gnt_q;
   assign bus.s    = s_q;
   assign bus.busy = busy_q;
endmodule
